// File: rtl/synth_pkg.sv
// Shared constants for the tone synthesiser: frame counter layout and
// phase accumulator width.
package synth_pkg;

    localparam int CNT_W    = 11;
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 4;
    localparam int LRCK_BIT = 10;
    localparam int SLOTS    = 32;
    localparam int PHASE_W  = 24;
    localparam int SLOT_W   = $clog2(SLOTS);

endpackage

// File: rtl/i2s_tx.sv
// I2S framing and serialiser. All outputs are registered copies of the
// frame counter's next value, so they line up exactly with cnt and never
// glitch. sdout changes only where the slot field rolls over, which is the
// falling edge of SCK.
module i2s_tx
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    cnt,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                mclk,
    output logic                sck,
    output logic                lrck,
    output logic                sdout
);

    logic              mclk_nxt;
    logic              sck_nxt;
    logic              lrck_nxt;
    logic              slot_edge;
    logic [SLOT_W-1:0] slot_nxt;
    logic [31:0]       sample_ext;
    logic              bit_nxt;

    // Each derived clock is bit b of cnt+1: bit b flips when all lower bits are 1.
    assign mclk_nxt  = cnt[MCLK_BIT] ^ (&cnt[MCLK_BIT-1:0]);
    assign sck_nxt   = cnt[SCK_BIT]  ^ (&cnt[SCK_BIT-1:0]);
    assign lrck_nxt  = cnt[LRCK_BIT] ^ (&cnt[LRCK_BIT-1:0]);
    assign slot_edge = &cnt[SCK_BIT:0];
    assign slot_nxt  = cnt[SCK_BIT+SLOT_W:SCK_BIT+1] + SLOT_W'(1);
    assign sample_ext = 32'(sample);

    // Bit for the slot about to start: slot 0 is the I2S delay bit, then MSB first, then zero padding.
    always_comb begin
        bit_nxt = 1'b0;
        if (slot_nxt != '0 && int'(slot_nxt) <= SAMPLE_W)
            bit_nxt = sample_ext[5'(SAMPLE_W - int'(slot_nxt))];
    end

    // Register the derived clocks and the serial data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mclk  <= 1'b0;
            sck   <= 1'b0;
            lrck  <= 1'b0;
            sdout <= 1'b0;
        end else begin
            mclk <= mclk_nxt;
            sck  <= sck_nxt;
            lrck <= lrck_nxt;
            if (slot_edge)
                sdout <= bit_nxt;
        end
    end

endmodule

// File: rtl/synth_top.sv
// Tone synthesiser top: frame counter, phase accumulator, waveform select
// and LED display, feeding the I2S transmitter.
// Build option: SYNTH_SAW_EN selects a sawtooth; otherwise a square wave.
module synth_top
    import synth_pkg::*;
#(
    parameter logic [PHASE_W-1:0] PHASE_INC = 24'd151183,
    parameter int                 SAMPLE_W  = 24
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] led,
    output logic       mclk,
    output logic       lrck,
    output logic       sck,
    output logic       sdout
);

    logic [CNT_W-1:0]    cnt;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  phase_nxt;
    logic [PHASE_W-1:0]  wave;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] sample_nxt;
    logic                frame_end;

    assign frame_end = &cnt;
    assign phase_nxt = phase + PHASE_INC;

    // Waveform computed from the phase the accumulator is about to take.
    always_comb begin
`ifdef SYNTH_SAW_EN
        wave = phase_nxt ^ {1'b1, {(PHASE_W-1){1'b0}}};
`else
        wave = phase_nxt[PHASE_W-1] ? {2'b00, {(PHASE_W-2){1'b1}}}
                                    : {2'b11, {(PHASE_W-2){1'b0}}};
`endif
    end

    // Fit the 24-bit waveform to the DAC width, keeping it left-justified.
    if (SAMPLE_W <= PHASE_W) begin : g_trunc
        assign sample_nxt = wave[PHASE_W-1 -: SAMPLE_W];
    end else begin : g_pad
        assign sample_nxt = {wave, {(SAMPLE_W-PHASE_W){1'b0}}};
    end

    // Free-running frame counter; wraps every 2048 clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Advance phase and latch a new sample once per frame, so L and R always match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= '0;
            sample <= '0;
            led    <= '0;
        end else if (frame_end) begin
            phase  <= phase_nxt;
            sample <= sample_nxt;
            led    <= sample_nxt[SAMPLE_W-1 -: 8];
        end
    end

    i2s_tx #(
        .SAMPLE_W (SAMPLE_W)
    ) u_i2s_tx (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt),
        .sample (sample),
        .mclk   (mclk),
        .sck    (sck),
        .lrck   (lrck),
        .sdout  (sdout)
    );

endmodule

// File: tb/tb_synth_top.sv
// Bench for synth_top: table of timed checks after reset, async reset,
// phase wrap-around, and randomized run lengths / reset points checked
// every cycle against a frame-level model.
module tb_synth_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led,  led2;
    logic       mclk, lrck, sck, sdout;
    logic       mclk2, lrck2, sck2, sdout2;

    synth_top #(.PHASE_INC(24'd151183), .SAMPLE_W(24)) dut (
        .clk(clk), .rst(rst), .led(led), .mclk(mclk),
        .lrck(lrck), .sck(sck), .sdout(sdout)
    );

    synth_top #(.PHASE_INC(24'h800000), .SAMPLE_W(24)) dut2 (
        .clk(clk), .rst(rst), .led(led2), .mclk(mclk2),
        .lrck(lrck2), .sck(sck2), .sdout(sdout2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tab[$];
    int   errors    = 0;
    int   checks    = 0;
    int   n         = 0;
    int   sck_rises = 0;
    logic sck_prev  = 1'b0;

    function automatic logic [23:0] wave_of(input logic [23:0] ph);
`ifdef SYNTH_SAW_EN
        return ph ^ 24'h800000;
`else
        return ph[23] ? 24'h3FFFFF : 24'hC00000;
`endif
    endfunction

    // Expected {mclk, sck, lrck, sdout, led} after `edges` clocks since reset release.
    function automatic logic [11:0] model(input int edges, input logic [23:0] inc);
        int          c;
        int          f;
        int          slot;
        longint      prod;
        logic [23:0] s;
        logic        sd;
        c    = edges % 2048;
        f    = edges / 2048;
        prod = longint'(f) * longint'(inc);
        s    = (f == 0) ? 24'h0 : wave_of(prod[23:0]);
        slot = (c / 32) % 32;
        sd   = (slot >= 1 && slot <= 24) ? s[24 - slot] : 1'b0;
        return {1'((c / 2) % 2), 1'((c / 16) % 2), 1'((c / 1024) % 2), sd, s[23:16]};
    endfunction

    function automatic void check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
        end
    endfunction

    function automatic void add(input int at, input logic [11:0] e, input string nm);
        vec_t v;
        v.n = at;
        v.exp = e;
        v.name = nm;
        tab.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) n++;
        @(negedge clk);
        if (!sck_prev && sck) sck_rises++;
        sck_prev = sck;
        check("model", {mclk, sck, lrck, sdout, led}, model(n, 24'd151183));
        check("model_inc800000", {mclk2, sck2, lrck2, sdout2, led2}, model(n, 24'h800000));
    endtask

    task automatic release_rst();
        step();
        step();
        rst = 1'b0;
        n = 0;
        sck_rises = 0;
        sck_prev = 1'b0;
    endtask

    task automatic mid_reset(input int at);
        while (n < at) step();
        @(posedge clk);
        n++;
        #2 rst = 1'b1;
        #1;
        check("async_rst", {mclk, sck, lrck, sdout, led}, 12'h000);
        check("async_rst_dut2", {mclk2, sck2, lrck2, sdout2, led2}, 12'h000);
        n = 0;
        @(negedge clk);
        release_rst();
    endtask

    task automatic run_table();
        foreach (tab[i]) begin
            while (n < tab[i].n) step();
            check(tab[i].name, {mclk, sck, lrck, sdout, led}, tab[i].exp);
            if (tab[i].n == 2048)
                check("sck_rises_per_frame", 12'(sck_rises), 12'd64);
        end
    endtask

    initial begin
        logic [23:0] s1;
        logic [7:0]  l1;
        logic [7:0]  wrap_led [4];
`ifdef SYNTH_SAW_EN
        s1 = 24'h824E8F;
        wrap_led = '{8'h00, 8'h80, 8'h00, 8'h80};
`else
        s1 = 24'hC00000;
        wrap_led = '{8'h3F, 8'hC0, 8'h3F, 8'hC0};
`endif
        l1 = s1[23:16];

        add(0,    12'h000, "reset_idle");
        add(1,    12'h000, "edge1");
        add(2,    12'h800, "mclk_rise");
        add(3,    12'h800, "mclk_hold");
        add(4,    12'h000, "mclk_fall");
        add(16,   12'h400, "sck_rise");
        add(31,   12'hC00, "sck_high");
        add(32,   12'h000, "sck_fall");
        add(100,  12'h000, "run100");
        add(1023, 12'hC00, "pre_lrck");
        add(1024, 12'h200, "lrck_rise");
        add(2047, 12'hE00, "frame_end");
        add(2048, {4'b0000, l1}, "frame2_start");
        add(2056, {4'b0000, l1}, "slot0_zero");
        for (int s = 1; s <= 24; s++)
            add(2048 + 32 * s + 8, {3'b000, s1[24 - s], l1}, "slot_bit");
        add(2048 + 32 * 25 + 1, {4'b0000, l1}, "slot25_zero");
        add(2048 + 32 * 31 + 2, {4'b1000, l1}, "slot31_zero");
        add(3072 + 32 + 8, {3'b001, s1[23], l1}, "right_slot1");

        release_rst();
        run_table();

        mid_reset(700);
        run_table();

        mid_reset(n + 100);
        for (int k = 1; k <= 4; k++) begin
            while (n < 2048 * k + 5) step();
            check("led_wrap", {4'b0000, led2}, {4'b0000, wrap_led[k-1]});
        end

        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(300, 3000));
            repeat (len) step();
            mid_reset(n + int'($urandom_range(1, 2000)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
